rr_arb4_64bit: RTL
==================

// Module: rr_arb4_64bit
// PURPOSE
//  Round-robin arbiter/sequencer sharing one 64-bit 4:1 select path (quadmux_64bit)
//  among four requesters A..D. Picks one pending requester per grant, drives the
//  mux select, captures the selected word into an output register, and holds it
//  under a valid/ready handshake until the consumer takes it. Sits between four
//  producer ports and a single shared 64-bit consumer (e.g. write-back or bus port).
// PARAMETERS
//  WIDTH      64   data width per requester and of Out
//  RESET_PTR  0    priority pointer value after reset (0=A,1=B,2=C,3=D)
// PORTS
//  clk       in   1      single clock; all state updates on rising edge
//  rst       in   1      synchronous, active-high reset
//  req       in   4      req[0]=A .. req[3]=D; held high with stable data until ack
//  InA       in   WIDTH  requester A data
//  InB       in   WIDTH  requester B data
//  InC       in   WIDTH  requester C data
//  InD       in   WIDTH  requester D data
//  ack       out  4      registered one-hot pulse, 1 cycle: requester's word captured
//  Out       out  WIDTH  registered captured word
//  OutValid  out  1      Out holds an untaken word
//  OutReady  in   1      consumer accepts Out this cycle when OutValid=1
//  LastSel   out  2      registered index of most recent grant (mux select used)
//  Busy      out  1      =OutValid (state HOLD)
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, Out=0, OutValid=0, ack=0, LastSel=0,
//   ptr=RESET_PTR. Overrides everything; word held in HOLD is discarded, no ack.
//  States: IDLE (output register empty), HOLD (OutValid=1).
//  Eligible set E = req & ~ack (requester acked this cycle is masked, so a req
//   not yet dropped is never granted twice for one word).
//  Grant g = first set bit of E scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
//  Mux select = g (combinational, internal quadmux_64bit instance); 00=A..11=D.
//  Capture condition CAP = (E!=0) & (state==IDLE | (state==HOLD & OutReady)).
//  On CAP edge: Out<=mux(g); OutValid<=1; ack<=onehot(g); LastSel<=g;
//   ptr<=g+1 (2-bit wrap, 3->0); state->HOLD.
//  HOLD & OutReady & E==0: OutValid<=0, state->IDLE, Out keeps last value.
//  HOLD & ~OutReady: Out, OutValid, LastSel, ptr frozen; ack<=0; no grant.
//  IDLE & E==0: nothing changes; ack<=0.
//  ack is 0 in every cycle not immediately following a CAP edge.
//  Latency: req seen at edge N (IDLE) -> Out/OutValid/ack valid after edge N.
//  Throughput: one word per cycle when OutReady=1 and requests pending
//   (simultaneous take + capture in HOLD).
//  OutReady while OutValid=0 is ignored. Data on InX sampled only on its grant edge.
//  Requester protocol: keep req/data stable until ack=1; may re-raise req the
//   cycle after ack for its next word.
// TESTING
//  T1 reset: rst=1 two cycles, random inputs -> Out=0,OutValid=0,ack=0,LastSel=0.
//  T2 single: req=0010,InB=64'hDEAD_BEEF_0123_4567 -> next cycle Out=that word,
//   OutValid=1,ack=0010,LastSel=1; OutReady=1,req=0 -> next cycle OutValid=0.
//  T3 fairness: req=1111 continuously, OutReady=1 -> grants A,B,C,D,A,B (LastSel
//   0,1,2,3,0,1), one word per cycle, no requester acked twice in a row.
//  T4 backpressure: OutValid=1,OutReady=0 for 5 cycles, req=0101 -> Out stable,
//   ack=0 all 5 cycles; OutReady=1 -> next eligible granted next cycle.
//  T5 wrap: after grant to D (ptr=0), req=1001 -> A granted (ack=0001), then D.
//  T6 reset mid-op: rst=1 while HOLD with word C -> next cycle OutValid=0,Out=0,
//   ack=0; ptr=RESET_PTR so req=1111 then grants A first.

Source files
------------

// File: rtl/rr_arb4_64bit.sv
`default_nettype none
// ============================================================================
// Module      : quadmux_64bit / rr_arb4_64bit
// Description : Four-way round-robin arbiter that shares one 4:1 word mux
//               among requesters A..D. The chosen word is captured into an
//               output register and held there under a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// quadmux_64bit : plain combinational 4:1 word select (00=A .. 11=D)
// ----------------------------------------------------------------------------
module quadmux_64bit #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] in_a_i,
  input  logic [WIDTH-1:0] in_b_i,
  input  logic [WIDTH-1:0] in_c_i,
  input  logic [WIDTH-1:0] in_d_i,
  input  logic [1:0]       sel_i,
  output logic [WIDTH-1:0] out_o
);

  // Select one of the four input words
  always_comb begin
    out_o = in_a_i;
    case (sel_i)
      2'd0:    out_o = in_a_i;
      2'd1:    out_o = in_b_i;
      2'd2:    out_o = in_c_i;
      2'd3:    out_o = in_d_i;
      default: out_o = in_a_i;
    endcase
  end

endmodule

// ----------------------------------------------------------------------------
// rr_arb4_64bit : round-robin arbiter with registered, handshaked output
// ----------------------------------------------------------------------------
module rr_arb4_64bit #(
  parameter int         WIDTH     = 64,
  parameter logic [1:0] RESET_PTR = 2'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req_i,
  input  logic [WIDTH-1:0] InA_i,
  input  logic [WIDTH-1:0] InB_i,
  input  logic [WIDTH-1:0] InC_i,
  input  logic [WIDTH-1:0] InD_i,
  output logic [3:0]       ack_o,
  output logic [WIDTH-1:0] Out_o,
  output logic             OutValid_o,
  input  logic             OutReady_i,
  output logic [1:0]       LastSel_o,
  output logic             Busy_o
);

  // IDLE: output register empty; HOLD: output register has an untaken word
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   out_q,   out_d;
  logic [3:0]         ack_q,   ack_d;
  logic [1:0]         lastsel_q, lastsel_d;
  logic [1:0]         ptr_q,   ptr_d;

  logic [3:0]         w_eligible;
  logic [1:0]         w_grant_idx;
  logic               w_grant_any;
  logic               w_cap;
  logic [WIDTH-1:0]   w_mux_out;

  // A requester acked last cycle may still hold req high for one cycle while
  // it reacts; masking it prevents granting the same word twice.
  assign w_eligible = req_i & ~ack_q;

  // Rotating priority scan starting at the pointer
  always_comb begin
    logic [1:0] cand;
    cand        = 2'd0;
    w_grant_any = 1'b0;
    w_grant_idx = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!w_grant_any && w_eligible[cand]) begin
        w_grant_any = 1'b1;
        w_grant_idx = cand;
      end
    end
  end

  // Shared word path, steered by the current grant
  quadmux_64bit #(
    .WIDTH (WIDTH)
  ) u_mux (
    .in_a_i (InA_i),
    .in_b_i (InB_i),
    .in_c_i (InC_i),
    .in_d_i (InD_i),
    .sel_i  (w_grant_idx),
    .out_o  (w_mux_out)
  );

  // Capture when the register is empty, or is being emptied this same cycle
  assign w_cap = w_grant_any && ((state_q == S_IDLE) || OutReady_i);

  // Next-state and datapath update decisions
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    ack_d     = 4'b0000;
    lastsel_d = lastsel_q;
    ptr_d     = ptr_q;
    if (w_cap) begin
      out_d     = w_mux_out;
      ack_d     = 4'b0001 << w_grant_idx;
      lastsel_d = w_grant_idx;
      ptr_d     = w_grant_idx + 2'd1;
      state_d   = S_HOLD;
    end else if ((state_q == S_HOLD) && OutReady_i) begin
      // Word taken with nothing new to load: Out keeps its last value
      state_d = S_IDLE;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      out_q     <= '0;
      ack_q     <= 4'b0000;
      lastsel_q <= 2'd0;
      ptr_q     <= RESET_PTR;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      ack_q     <= ack_d;
      lastsel_q <= lastsel_d;
      ptr_q     <= ptr_d;
    end
  end

  assign ack_o      = ack_q;
  assign Out_o      = out_q;
  assign OutValid_o = (state_q == S_HOLD);
  assign Busy_o     = (state_q == S_HOLD);
  assign LastSel_o  = lastsel_q;

endmodule

`default_nettype wire
